// File: rtl/adc_serial_capture.sv
// adc_serial_capture: chip-select driven serial ADC capture for N_CH parallel data lines.
// Ports:
//   Clock_Muestreo  sample clock, rising edge
//   reset           asynchronous active-high reset
//   start           single-conversion request, taken in IDLE only
//   continuous      back-to-back conversion enable
//   read_ack        consumer acknowledge of Dato
//   data_ADC        serial data, bit i from channel i, MSB first
//   CS              active-low chip select, registered
//   busy            high whenever the FSM is not IDLE
//   done            one-cycle pulse per completed frame
//   valid           Dato holds unacknowledged data
//   Dato            channel i at [i*DATA_W +: DATA_W]
//   overrun         sticky lost-sample flag
//   frame_err       discarded leading bits of last frame were not all zero
module adc_serial_capture #(
    parameter int DATA_W    = 12,
    parameter int FRAME_W   = 16,
    parameter int N_CH      = 2,
    parameter int QUIET_CYC = 1
) (
    input  logic                   Clock_Muestreo,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   continuous,
    input  logic                   read_ack,
    input  logic [N_CH-1:0]        data_ADC,
    output logic                   CS,
    output logic                   busy,
    output logic                   done,
    output logic                   valid,
    output logic [N_CH*DATA_W-1:0] Dato,
    output logic                   overrun,
    output logic                   frame_err
);
    // One counter serves both the bit position and the quiet-gap length.
    localparam int CNT_MAX = FRAME_W > QUIET_CYC ? FRAME_W : QUIET_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    typedef enum logic [1:0] {IDLE, CAPTURE, DONE, QUIET} state_t;
    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic               cs_n, err_n;
    logic [FRAME_W-1:0] sh [N_CH];
    assign busy = state != IDLE;
    always_comb begin
        state_n = IDLE;
        cnt_n   = '0;
        cs_n    = 1'b1;
        err_n   = 1'b0;
        // Bits above DATA_W are the leading frame bits; shifting by DATA_W leaves only them.
        for (int i = 0; i < N_CH; i++) err_n = err_n | (|(sh[i] >> DATA_W));
        case (state)
            IDLE: if (start || continuous) begin
                state_n = CAPTURE;
                cs_n    = 1'b0;
            end
            CAPTURE: if (cnt != CW'(FRAME_W - 1)) begin
                state_n = CAPTURE;
                cnt_n   = cnt + 1'b1;
                cs_n    = 1'b0;
            end else state_n = DONE;
            DONE: state_n = QUIET;
            QUIET: if (cnt != CW'(QUIET_CYC - 1)) begin
                state_n = QUIET;
                cnt_n   = cnt + 1'b1;
            end else if (continuous) begin
                state_n = CAPTURE;
                cs_n    = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge Clock_Muestreo or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            CS        <= 1'b1;
            done      <= 1'b0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            Dato      <= '0;
            for (int i = 0; i < N_CH; i++) sh[i] <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            CS      <= cs_n;
            done    <= state == DONE;
            // A new frame wins over a simultaneous acknowledge, so valid stays set.
            valid   <= (state == DONE) || (valid && !read_ack);
            overrun <= overrun || (state == DONE && valid && !read_ack);
            if (state == DONE) frame_err <= err_n;
            for (int i = 0; i < N_CH; i++) begin
                if (state == CAPTURE) sh[i] <= (sh[i] << 1) | FRAME_W'(data_ADC[i]);
                if (state == DONE) Dato[i*DATA_W +: DATA_W] <= sh[i][DATA_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_adc_serial_capture.sv
// tb_adc_serial_capture: directed checks of adc_serial_capture with a CS-driven serial ADC model.
module tb_adc_serial_capture;
    logic        clk = 1'b0;
    logic        reset, start, continuous, read_ack;
    logic [1:0]  data_ADC;
    logic        CS, busy, done, valid, overrun, frame_err;
    logic [23:0] Dato;
    logic [15:0] fr0, fr1;
    int          n_vec = 0, n_err = 0;
    int          lat, lows, d1, d2, d3, highs;

    adc_serial_capture dut (
        .Clock_Muestreo(clk), .reset(reset), .start(start), .continuous(continuous),
        .read_ack(read_ack), .data_ADC(data_ADC), .CS(CS), .busy(busy), .done(done),
        .valid(valid), .Dato(Dato), .overrun(overrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // ADC model: presents the next frame bit, MSB first, on each falling edge while CS is low.
    initial begin
        int idx;
        idx = 0;
        data_ADC = '0;
        forever begin
            @(negedge clk);
            if (!CS && idx < 16) begin
                data_ADC = {fr1[15-idx], fr0[15-idx]};
                idx++;
            end else if (CS) idx = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Single-shot frame; returns done latency (falling edges after the start edge) and CS-low count.
    task automatic run_single(input int poke, output int lat_o, output int lows_o);
        lat_o = 0;
        lows_o = 0;
        start = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            start = (n == poke);
            if (!CS) lows_o++;
            if (done && lat_o == 0) lat_o = n;
            if (lat_o != 0 && n == lat_o + 1) break;
        end
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; continuous = 1'b0; read_ack = 1'b0;
        fr0 = 16'h0ABC; fr1 = 16'h0123;
        @(negedge clk);
        chk("rst_cs", CS, 1); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_valid", valid, 0); chk("rst_ovr", overrun, 0);
        chk("rst_ferr", frame_err, 0); chk("rst_dato", Dato, 0);
        reset = 1'b0;
        @(negedge clk);

        run_single(0, lat, lows);
        chk("s1_lat", lat, 18); chk("s1_cslow", lows, 16);
        chk("s1_dato", Dato, 24'h123ABC); chk("s1_valid", valid, 1);
        chk("s1_ferr", frame_err, 0); chk("s1_done_1cyc", done, 0); chk("s1_busy", busy, 0);

        read_ack = 1'b1;
        @(negedge clk);
        read_ack = 1'b0;
        chk("ack_valid", valid, 0);
        read_ack = 1'b1;
        @(negedge clk);
        read_ack = 1'b0;
        chk("ack_idle_valid", valid, 0); chk("ack_idle_ovr", overrun, 0);
        chk("hold_dato", Dato, 24'h123ABC);

        fr0 = 16'h8FFF;
        run_single(0, lat, lows);
        chk("e_dato", Dato, 24'h123FFF); chk("e_ferr", frame_err, 1); chk("e_ovr", overrun, 0);

        fr0 = 16'h0ABC; fr1 = 16'h0456;
        run_single(0, lat, lows);
        chk("o_dato", Dato, 24'h456ABC); chk("o_ovr", overrun, 1); chk("o_ferr", frame_err, 0);

        fr1 = 16'h0123;
        start = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("mr_cs_pre", CS, 0);
        reset = 1'b1;
        #1;
        chk("mr_cs", CS, 1); chk("mr_dato", Dato, 0); chk("mr_valid", valid, 0);
        chk("mr_ovr", overrun, 0); chk("mr_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("mr_idle_busy", busy, 0); chk("mr_idle_cs", CS, 1);
        run_single(0, lat, lows);
        chk("mr_lat", lat, 18); chk("mr_new_dato", Dato, 24'h123ABC);

        run_single(5, lat, lows);
        chk("ign_lat", lat, 18); chk("ign_busy", busy, 0);
        @(negedge clk);
        chk("ign_busy2", busy, 0);

        pulse_reset();
        continuous = 1'b1;
        d1 = 0; d2 = 0; d3 = 0; highs = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 40) continuous = 1'b0;
            if (n >= 19 && n <= 36 && CS) highs++;
            if (done) begin
                if (d1 == 0) begin
                    d1 = n;
                    chk("c_ovr_first", overrun, 0);
                end else if (d2 == 0) begin
                    d2 = n;
                    chk("c_ovr_second", overrun, 1);
                    chk("c_dato", Dato, 24'h123ABC);
                end else d3 = n;
            end
            if (d3 != 0 && n == d3 + 1) chk("c_stop_busy", busy, 0);
        end
        chk("c_done1", d1, 18); chk("c_done2", d2, 36); chk("c_done3", d3, 54);
        chk("c_cs_gap", highs, 2);

        pulse_reset();
        continuous = 1'b1;
        for (int n = 1; n <= 56; n++) begin
            @(negedge clk);
            read_ack = (n % 18 == 17);
            if (n == 40) continuous = 1'b0;
            if (n == 19) chk("a_valid1", valid, 1);
            if (n == 54) begin
                chk("a_done3", done, 1); chk("a_valid3", valid, 1); chk("a_ovr", overrun, 0);
            end
        end
        read_ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
